// File: rtl/disp_scan_ctrl_if.sv
// disp_scan_ctrl_if: signal bundle between the display scan controller and
// its consumers (nibble mux select, anode drivers, other blinking logic).
//   master : drives en / blank_mask / blink_mask, observes scan outputs
//   slave  : the scan controller itself
interface disp_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                  en;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic [NUM_DIGITS-1:0] blink_mask;
    logic [2:0]            digit_sel;
    logic [NUM_DIGITS-1:0] an_n;
    logic                  dp_n;
    logic                  frame_tick;
    logic                  blink_phase;

    modport master (
        output en, blank_mask, blink_mask,
        input  digit_sel, an_n, dp_n, frame_tick, blink_phase
    );

    modport slave (
        input  en, blank_mask, blink_mask,
        output digit_sel, an_n, dp_n, frame_tick, blink_phase
    );
endinterface

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed 7-segment scan controller.
// Each digit slot is SCAN_DIV cycles: DEAD_CYC cycles with every anode off
// (anti-ghosting) followed by the lit portion. Per-digit blanking and
// blinking; blink phase toggles every BLINK_FRAMES full frames.
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   bus.en                scan enable (low forces IDLE and clears counters)
//   bus.blank_mask/blink_mask  per-digit dark / blink-dark controls
//   bus.digit_sel         current digit index (mux select)
//   bus.an_n              active-low anodes, one-hot-low or all-high
//   bus.dp_n              active-low decimal point / colon
//   bus.frame_tick        one-cycle pulse on the last->first digit wrap
//   bus.blink_phase       current blink phase
// Optional: define DISP_SCAN_COLON_EN to drive the colon (dp_n low during
// the lit part of digit 1 while blink_phase=0, obeying blank_mask[1]).
// All outputs are registered; they are computed from next-state values so
// each output lines up with the state it belongs to.
module disp_scan_ctrl #(
    parameter int SCAN_DIV     = 100000,
    parameter int DEAD_CYC     = 2000,
    parameter int NUM_DIGITS   = 4,
    parameter int BLINK_FRAMES = 125
) (
    input  logic               clk,
    input  logic               rst_n,
    disp_scan_ctrl_if.slave    bus
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] DEAD_LAST  = PW'(DEAD_CYC - 1);
    localparam logic [FW-1:0] FCNT_LAST  = FW'(BLINK_FRAMES - 1);
    localparam logic [2:0]    DIG_LAST   = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, DEAD, ON} state_t;

    state_t                state, state_n;
    logic [PW-1:0]         presc, presc_n;
    logic [2:0]            digit, digit_n;
    logic [FW-1:0]         fcnt, fcnt_n;
    logic                  phase, phase_n;
    logic                  tick_n, tick_q;
    logic [NUM_DIGITS-1:0] an_d, an_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            presc  <= '0;
            digit  <= '0;
            fcnt   <= '0;
            phase  <= 1'b0;
            tick_q <= 1'b0;
            an_q   <= '1;
        end else begin
            state  <= state_n;
            presc  <= presc_n;
            digit  <= digit_n;
            fcnt   <= fcnt_n;
            phase  <= phase_n;
            tick_q <= tick_n;
            an_q   <= an_d;
        end
    end

    always_comb begin
        state_n = state;
        presc_n = presc;
        digit_n = digit;
        fcnt_n  = fcnt;
        phase_n = phase;
        tick_n  = 1'b0;
        if (!bus.en) begin
            state_n = IDLE;
            presc_n = '0;
            digit_n = '0;
            fcnt_n  = '0;
            phase_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    presc_n = '0;
                    digit_n = '0;
                    state_n = (DEAD_CYC == 0) ? ON : DEAD;
                end
                DEAD: begin
                    presc_n = presc + PW'(1);
                    if (presc == DEAD_LAST) state_n = ON;
                end
                ON: begin
                    if (presc == PRESC_LAST) begin
                        presc_n = '0;
                        state_n = (DEAD_CYC == 0) ? ON : DEAD;
                        if (digit == DIG_LAST) begin
                            // frame wrap: also covers NUM_DIGITS=1 (0 -> 0)
                            digit_n = '0;
                            tick_n  = 1'b1;
                            if (fcnt == FCNT_LAST) begin
                                fcnt_n  = '0;
                                phase_n = ~phase;
                            end else begin
                                fcnt_n = fcnt + FW'(1);
                            end
                        end else begin
                            digit_n = digit + 3'd1;
                        end
                    end else begin
                        presc_n = presc + PW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Anode per digit: lit only in ON, on the selected digit, and unmasked.
    // Masks are live inputs so a change shows up at the very next edge.
    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_an
        assign an_d[d] = !((state_n == ON) && (digit_n == 3'(d)) &&
                           !bus.blank_mask[d] &&
                           !(bus.blink_mask[d] && phase_n));
    end

    assign bus.digit_sel   = digit;
    assign bus.an_n        = an_q;
    assign bus.frame_tick  = tick_q;
    assign bus.blink_phase = phase;

`ifdef DISP_SCAN_COLON_EN
    logic [7:0] blank_pad;
    logic       dp_d, dp_q;

    // padded so digit 1's blank bit exists even for NUM_DIGITS=1
    assign blank_pad = 8'(bus.blank_mask);
    // colon blinks with the global phase, independent of blink_mask[1]
    assign dp_d = !((state_n == ON) && (digit_n == 3'd1) && !phase_n &&
                    !blank_pad[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dp_q <= 1'b1;
        else        dp_q <= dp_d;
    end

    assign bus.dp_n = dp_q;
`else
    assign bus.dp_n = 1'b1;
`endif
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: two instances (DEAD_CYC=2 and DEAD_CYC=0) share
// stimulus. A time-since-enable reference model predicts outputs after each
// edge; predictions are queued and a negedge monitor pops and compares.
module tb_disp_scan_ctrl;
    localparam int S = 8;
    localparam int N = 4;
    localparam int B = 2;

    typedef struct packed {
        logic [2:0] sel;
        logic [3:0] an;
        logic       dp;
        logic       tick;
        logic       ph;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t qa[$];
    exp_t qb[$];
    bit   act = 1'b0;
    int   t = 0;

    always #5 clk = ~clk;

    disp_scan_ctrl_if #(.NUM_DIGITS(N)) bus_a ();
    disp_scan_ctrl_if #(.NUM_DIGITS(N)) bus_b ();

    disp_scan_ctrl #(.SCAN_DIV(S), .DEAD_CYC(2), .NUM_DIGITS(N), .BLINK_FRAMES(B))
        u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    disp_scan_ctrl #(.SCAN_DIV(S), .DEAD_CYC(0), .NUM_DIGITS(N), .BLINK_FRAMES(B))
        u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    // Expected outputs t edges after the edge that first saw en high.
    function automatic exp_t model(int dead, bit active, int tt,
                                   logic [3:0] bl, logic [3:0] bk);
        exp_t e;
        int slot, pos, d, frame;
        bit on, ph;
        e.sel = 3'd0; e.an = 4'hF; e.dp = 1'b1; e.tick = 1'b0; e.ph = 1'b0;
        if (active) begin
            slot  = tt / S;
            pos   = tt % S;
            d     = slot % N;
            frame = slot / N;
            ph    = ((frame / B) % 2) == 1;
            on    = pos >= dead;
            e.sel  = 3'(d);
            e.ph   = ph;
            e.tick = (tt > 0) && (pos == 0) && (d == 0);
            if (on && !bl[d] && !(bk[d] && ph)) e.an[d] = 1'b0;
`ifdef DISP_SCAN_COLON_EN
            if (on && d == 1 && !ph && !bl[1]) e.dp = 1'b0;
`endif
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic push_exp();
        qa.push_back(model(2, act, t, bus_a.blank_mask, bus_a.blink_mask));
        qb.push_back(model(0, act, t, bus_b.blank_mask, bus_b.blink_mask));
    endtask

    // One cycle: drive at negedge, DUT samples at posedge, model follows.
    task automatic cyc(input logic r, input logic e, input logic [3:0] bl,
                       input logic [3:0] bk);
        @(negedge clk);
        rst_n = r;
        bus_a.en = e; bus_a.blank_mask = bl; bus_a.blink_mask = bk;
        bus_b.en = e; bus_b.blank_mask = bl; bus_b.blink_mask = bk;
        @(posedge clk);
        if (!r || !e) act = 1'b0;
        else if (!act) begin act = 1'b1; t = 0; end
        else t++;
        push_exp();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("a.digit_sel",   32'(bus_a.digit_sel),   32'(e.sel));
            chk("a.an_n",        32'(bus_a.an_n),        32'(e.an));
            chk("a.dp_n",        32'(bus_a.dp_n),        32'(e.dp));
            chk("a.frame_tick",  32'(bus_a.frame_tick),  32'(e.tick));
            chk("a.blink_phase", 32'(bus_a.blink_phase), 32'(e.ph));
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("b.digit_sel",   32'(bus_b.digit_sel),   32'(e.sel));
            chk("b.an_n",        32'(bus_b.an_n),        32'(e.an));
            chk("b.dp_n",        32'(bus_b.dp_n),        32'(e.dp));
            chk("b.frame_tick",  32'(bus_b.frame_tick),  32'(e.tick));
            chk("b.blink_phase", 32'(bus_b.blink_phase), 32'(e.ph));
        end
    end

    initial begin
        logic [3:0] bl, bk;
        logic       en;
        bus_a.en = 1'b0; bus_a.blank_mask = '0; bus_a.blink_mask = '0;
        bus_b.en = 1'b0; bus_b.blank_mask = '0; bus_b.blink_mask = '0;

        // reset held, then enable; run into digit 2 lit (t=19)
        repeat (3) cyc(1'b0, 1'b1, 4'h0, 4'h0);
        repeat (20) cyc(1'b1, 1'b1, 4'h0, 4'h0);

        // async reset between edges: outputs must clear before the next edge
        @(negedge clk);
        chk("pre_rst.digit_sel", 32'(bus_a.digit_sel), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.an_n",       32'(bus_a.an_n),       32'hF);
        chk("arst.digit_sel",  32'(bus_a.digit_sel),  32'd0);
        chk("arst.frame_tick", 32'(bus_a.frame_tick), 32'd0);
        chk("arst.dp_n",       32'(bus_a.dp_n),       32'd1);
        chk("arst.b.an_n",     32'(bus_b.an_n),       32'hF);
        @(posedge clk);
        act = 1'b0;
        push_exp();
        repeat (2) cyc(1'b0, 1'b1, 4'h0, 4'h0);

        // plain scan through two blink toggles
        repeat (140) cyc(1'b1, 1'b1, 4'h0, 4'h0);
        // blink digit 0
        repeat (160) cyc(1'b1, 1'b1, 4'h0, 4'h1);
        // blank digit 2, then clear mid-slot
        repeat (45) cyc(1'b1, 1'b1, 4'h4, 4'h0);
        repeat (20) cyc(1'b1, 1'b1, 4'h0, 4'h0);

        // en drop during digit 1 lit, then restart
        repeat (2) cyc(1'b0, 1'b0, 4'h0, 4'h0);
        cyc(1'b1, 1'b0, 4'h0, 4'h0);
        repeat (12) cyc(1'b1, 1'b1, 4'h0, 4'h0);
        cyc(1'b1, 1'b0, 4'h0, 4'h0);
        repeat (40) cyc(1'b1, 1'b1, 4'h0, 4'h2);

        // randomized: rare en drops, sparse mask changes
        bl = '0; bk = '0;
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 15) == 0) bl = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 15) == 0) bk = 4'($urandom);
            cyc(1'b1, en, bl, bk);
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(qa.size() + qb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Time-multiplexed 7-segment scan controller for the alarm-clock display.
- Sits directly upstream of the nibble mux. Its digit_sel drives the mux select; the same-cycle an_n enables one common-anode digit.
- Adds per-digit blanking, per-digit blinking for the alarm/time-set modes, and an anti-ghosting dead time between digits.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz). Must be > DEAD_CYC.
- DEAD_CYC, 2000: cycles per slot with all anodes off before a digit lights. 0 = no dead time.
- NUM_DIGITS, 4: digits scanned, range 1..8.
- BLINK_FRAMES, 125: full scan frames per blink-phase toggle (1 Hz blink at defaults).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable
- blank_mask  in  NUM_DIGITS  1 = digit permanently dark
- blink_mask  in  NUM_DIGITS  1 = digit dark while blink_phase=1
- digit_sel  out  3  current digit index to mux select
- an_n  out  NUM_DIGITS  active-low anode enables, one-hot-low or all-high
- dp_n  out  1  active-low decimal point / colon
- frame_tick  out  1  one-cycle pulse at end of each full frame
- blink_phase  out  1  current blink phase, exported for other blinking logic

Behaviour:
- Reset state (async on rst_n=0, all outputs registered):
  - state=IDLE, prescaler=0, frame count=0, blink_phase=0
  - digit_sel=0, an_n=all 1, dp_n=1, frame_tick=0
- States:
  - IDLE: an_n all 1; counters held at 0. On en=1 at an edge -> DEAD, or -> ON if DEAD_CYC=0.
  - DEAD: an_n all 1; digit_sel already shows the new digit. Exits to ON after DEAD_CYC cycles.
  - ON: an_n[digit_sel]=0 unless masked. Runs SCAN_DIV-DEAD_CYC cycles. Then digit_sel <= (digit_sel+1) mod NUM_DIGITS, prescaler clears, -> DEAD (or ON if DEAD_CYC=0).
- Slot timing:
  - One prescaler counts 0..SCAN_DIV-1 across each slot; DEAD covers counts 0..DEAD_CYC-1.
  - A slot is exactly SCAN_DIV cycles; a frame is NUM_DIGITS*SCAN_DIV cycles.
- Latency: en seen high at edge k -> first anode low at edge k+DEAD_CYC.
- Masking: digit d stays dark if blank_mask[d], or if blink_mask[d] and blink_phase=1.
  - Masks are sampled every cycle, so a change takes effect at the next edge, even mid-slot.
  - Masking never alters digit_sel sequencing.
- Frame wrap: on the digit_sel transition NUM_DIGITS-1 -> 0, frame_tick=1 for exactly one cycle.
  - The frame counter increments on each frame_tick, wrapping at BLINK_FRAMES-1.
  - On that wrap, blink_phase toggles in the same cycle.
- NUM_DIGITS=1: digit_sel stays 0; frame_tick pulses every SCAN_DIV cycles.
- en deasserted in any state: the next edge forces IDLE, an_n all 1, digit_sel=0, prescaler/frame counter/blink_phase cleared, no frame_tick.
- rst_n low mid-operation: outputs reach reset values immediately. The first state advance occurs at the first clk edge after rst_n rises with en=1.
- Invariant: at most one an_n bit low in any cycle; an_n never low outside ON.

Optional Feature:
- Macro: DISP_SCAN_COLON_EN
- Defined:
  - dp_n=0 while state=ON, digit_sel=1 (colon between hours and minutes), and blink_phase=0. Otherwise dp_n=1.
  - dp_n obeys blank_mask[1] but ignores blink_mask[1].
- Undefined: dp_n tied to 1; no related logic.

Test Plan (SCAN_DIV=8, DEAD_CYC=2, NUM_DIGITS=4, BLINK_FRAMES=2 unless stated):
- Async reset: assert rst_n=0 mid-ON of digit 2 between edges -> an_n=1111, digit_sel=0, frame_tick=0, dp_n=1 before the next edge.
- Scan order: rst_n=1, en=1 -> digit_sel cycles 0,1,2,3,0 every 8 cycles. Per slot, an_n is 1111 for 2 cycles, then 1110/1101/1011/0111 for 6 cycles.
- Frame and blink: frame_tick is a one-cycle pulse every 32 cycles at each 3->0 transition. blink_phase toggles every 64 cycles. blink_mask=0001 -> digit 0 lit in frames 0-1, dark in frames 2-3, repeating.
- Blanking: blank_mask=0100 -> an_n stays 1111 throughout the digit-2 slot while digit_sel still reads 2. Clearing the mask mid-slot lights digit 2 at the next edge.
- En drop/restart: en=0 during digit 1 ON -> next edge an_n=1111, digit_sel=0, blink_phase=0. en=1 again -> 2 dead cycles, then an_n=1110.
- DEAD_CYC=0 with DISP_SCAN_COLON_EN: an_n is never 1111 between slots. dp_n=0 for all 8 cycles of digit 1 while blink_phase=0, and 1 otherwise.
